// File: rtl/punc_mem_responder_if.sv
// Request/response channel between the PUnC datapath (master) and the memory responder (slave).
// Both channels use valid/ready; the response is held until the requester takes it.
interface punc_mem_responder_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/punc_mem_responder.sv
// Word-addressed memory responder for the PUnC LC3 datapath: one outstanding request,
// programmable wait states, held registered response, and a side-band preload port.
module punc_mem_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    punc_mem_responder_if.slave   bus,
    input  logic                  i_load_en,
    input  logic [DEPTH_LOG2-1:0] i_load_addr,
    input  logic [DATA_W-1:0]     i_load_data,
    output logic                  o_busy
);

    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [3:0]          r_cnt;
    logic [3:0]          w_nextCnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                  w_accept;
    logic                  w_access;
    logic                  w_accWe;
    logic [ADDR_W-1:0]     w_accAddr;
    logic [DATA_W-1:0]     w_accWdata;
    logic                  w_inRange;
    logic [DEPTH_LOG2-1:0] w_memIdx;

    // With zero wait states the access happens on the accept edge, so the operands
    // must come straight from the bus rather than from the latched copy.
    always_comb begin
        w_accept   = (r_state == S_IDLE) && bus.req_valid && !i_load_en;
        w_accWe    = (r_state == S_IDLE) ? bus.req_we    : r_we;
        w_accAddr  = (r_state == S_IDLE) ? bus.req_addr  : r_addr;
        w_accWdata = (r_state == S_IDLE) ? bus.req_wdata : r_wdata;
        w_inRange  = (w_accAddr >> DEPTH_LOG2) == '0;
        w_memIdx   = w_accAddr[DEPTH_LOG2-1:0];
    end

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_access    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_nextCnt = WAIT_INIT;
                    if (WAIT_CYCLES == 0) begin
                        w_access    = 1'b1;
                        w_nextState = S_RESP;
                    end else begin
                        w_nextState = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_nextCnt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_access    = 1'b1;
                    w_nextState = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            if (w_accept) begin
                r_we    <= bus.req_we;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
            end
            if (w_access) begin
                r_err   <= !w_inRange;
                r_rdata <= (w_inRange && !w_accWe) ? r_mem[w_memIdx] : '0;
            end
        end
    end

    // Storage is never cleared; a preload on the same edge as a pending write lands last.
    always_ff @(posedge clk) begin
        if (!rst && w_access && w_accWe && w_inRange) begin
            r_mem[w_memIdx] <= w_accWdata;
        end
        if (i_load_en) begin
            r_mem[i_load_addr] <= i_load_data;
        end
    end

    assign bus.req_ready = (r_state == S_IDLE) && !i_load_en;
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;
    assign o_busy        = (r_state != S_IDLE);

endmodule
